// File: rtl/fsm1001_ov2.sv
// Overlapping Mealy detector for the serial pattern "1001".
// One bit is consumed per rising clock edge. The detect flag is combinational
// and is high during the cycle in which the final '1' of a match sits on `in`.
// That final '1' is kept as the first '1' of the next candidate, so matches
// may overlap ("1001001" gives two detections).
module fsm1001_ov2 (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  // Each state records the longest useful prefix of "1001" seen so far.
  typedef enum logic [1:0] {
    S0 = 2'b00,  // no useful prefix
    S1 = 2'b01,  // "1"
    S2 = 2'b10,  // "10"
    S3 = 2'b11   // "100"
  } state_t;

  state_t state;
  state_t state_next;

  // State register; reset discards any partial prefix.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S0;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A '1' always leaves the FSM in S1: either it starts a
  // new candidate or, in S3, it completes a match and is reused as the
  // leading '1' of the next one.
  always_comb begin
    state_next = S0;
    case (state)
      S0:      state_next = in ? S1 : S0;
      S1:      state_next = in ? S1 : S2;
      S2:      state_next = in ? S1 : S3;
      S3:      state_next = in ? S1 : S0;
      default: state_next = S0;
    endcase
  end

  // Mealy detect flag, gated off while reset is asserted.
  always_comb begin
    out = 1'b0;
    if (!rst && (state == S3) && in) begin
      out = 1'b1;
    end
  end

endmodule

// File: tb/tb_fsm1001_ov2.sv
// Testbench for fsm1001_ov2: drives serial streams, predicts the detect flag
// from a history of the bits accepted since the last reset, and compares
// the DUT output through a scoreboard queue.
module tb_fsm1001_ov2;

  logic clk;
  logic rst;
  logic in;
  logic out;

  int checks;
  int failures;

  // Reference model: last three accepted bits and how many bits have been
  // accepted since reset.
  logic [2:0] hist;
  int         nbits;

  logic exp_q[$];
  int   detections;

  fsm1001_ov2 dut (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: out=%b expected=%b at t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic logic model_out(input logic r, input logic b);
    return !r && b && (nbits >= 3) && (hist == 3'b100);
  endfunction

  // Apply one bit: drive on the falling edge, push the prediction, sample the
  // combinational output mid-cycle, then advance the model on the rising edge.
  task automatic step(input string tag, input logic r, input logic b);
    logic want;
    @(negedge clk);
    rst = r;
    in  = b;
    exp_q.push_back(model_out(r, b));
    #2;
    want = exp_q.pop_front();
    if (out === 1'b1) detections++;
    check_bit(tag, out, want);
    @(posedge clk);
    if (r) begin
      hist  = 3'b000;
      nbits = 0;
    end else begin
      hist  = {hist[1:0], b};
      nbits = nbits + 1;
    end
  endtask

  task automatic stream(input string tag, input logic [15:0] bits, input int len);
    for (int i = len - 1; i >= 0; i--) begin
      step(tag, 1'b0, bits[i]);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    hist       = 3'b000;
    nbits      = 0;
    detections = 0;
    rst        = 1'b1;
    in         = 1'b0;

    // Reset behaviour, including reset held with in=1.
    step("reset_in0", 1'b1, 1'b0);
    step("reset_in1", 1'b1, 1'b1);
    step("reset_in1b", 1'b1, 1'b1);

    // Basic match followed by the extended stream 1001010010.
    detections = 0;
    stream("basic", 16'b0000_0010_0101_0010, 10);
    checks++;
    if (detections != 2) begin
      failures++;
      $display("FAIL basic_count: detections=%0d expected=2", detections);
    end

    // Overlap: 1001001 gives two detections.
    step("ovl_rst", 1'b1, 1'b0);
    detections = 0;
    stream("overlap", 16'b0000_0000_0100_1001, 7);
    checks++;
    if (detections != 2) begin
      failures++;
      $display("FAIL overlap_count: detections=%0d expected=2", detections);
    end

    // Near misses: 1010001101 never detects.
    step("nm_rst", 1'b1, 1'b0);
    detections = 0;
    stream("near_miss", 16'b0000_0010_1000_1101, 10);
    checks++;
    if (detections != 0) begin
      failures++;
      $display("FAIL near_miss_count: detections=%0d expected=0", detections);
    end

    // Mid-stream reset: 100, reset (with in=1 while in S3), then 1, then 001.
    step("mid_rst0", 1'b1, 1'b0);
    detections = 0;
    stream("mid_pre", 16'b0000_0000_0000_0100, 3);
    step("mid_rst_in1", 1'b1, 1'b1);
    step("mid_after", 1'b0, 1'b1);
    stream("mid_tail", 16'b0000_0000_0000_0001, 3);
    checks++;
    if (detections != 1) begin
      failures++;
      $display("FAIL mid_count: detections=%0d expected=1", detections);
    end

    // Random stream with occasional resets.
    for (int i = 0; i < 300; i++) begin
      step("random", ($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1);
    end

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_empty: left=%0d expected=0", exp_q.size());
    end
    checks++;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
